fetch_sequencer: RTL

//  Control FSM for the IF/ID fetch datapath: PC register, PC+1 adder, PC mux,

---
 rtl/fetch_sequencer_if.sv | 51 +++++
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Handshake/control bundle between the fetch sequencer (master) and the loader/datapath (slave).
// Optional performance counters appear only when FETCH_SEQ_PERF_EN is defined.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              im_WE;
  logic [ADDR_W-1:0] im_ADDRESS;
  logic [DATA_W-1:0] im_DATA;
  logic              im_sel_load;
  logic              pc_RESET;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              branch_taken;
  logic              hazard;
  logic              halt_instr;
  logic              load_err;
  logic [2:0]        state_o;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0]       cyc_cnt;
  logic [31:0]       stall_cnt;

  modport master (
    input  start, ld_valid, ld_data, ld_last, branch_taken, hazard, halt_instr,
    output ld_ready, im_WE, im_ADDRESS, im_DATA, im_sel_load, pc_RESET, pc_en,
           ifid_en, ifid_flush, load_err, state_o, cyc_cnt, stall_cnt
  );
  modport slave (
    output start, ld_valid, ld_data, ld_last, branch_taken, hazard, halt_instr,
    input  ld_ready, im_WE, im_ADDRESS, im_DATA, im_sel_load, pc_RESET, pc_en,
           ifid_en, ifid_flush, load_err, state_o, cyc_cnt, stall_cnt
  );
`else
  modport master (
    input  start, ld_valid, ld_data, ld_last, branch_taken, hazard, halt_instr,
    output ld_ready, im_WE, im_ADDRESS, im_DATA, im_sel_load, pc_RESET, pc_en,
           ifid_en, ifid_flush, load_err, state_o
  );
  modport slave (
    output start, ld_valid, ld_data, ld_last, branch_taken, hazard, halt_instr,
    input  ld_ready, im_WE, im_ADDRESS, im_DATA, im_sel_load, pc_RESET, pc_en,
           ifid_en, ifid_flush, load_err, state_o
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Control FSM for the IF/ID fetch datapath: boot-load, PC clear, run/stall/flush/halt.
// Define FETCH_SEQ_PERF_EN to add the cyc_cnt/stall_cnt performance counters.
module fetch_sequencer #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic               CLK,
  input logic               RESET,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    RUN   = 3'd3,
    STALL = 3'd4,
    FLUSH = 3'd5,
    HALT  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              err_q, err_d;
  logic              start_ok;

  logic ld_ready, im_we, sel_load, pc_reset, pc_en, ifid_en, ifid_flush;

  assign start_ok = bus.start && (state_q == IDLE || state_q == HALT);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    fcnt_d     = fcnt_q;
    err_d      = err_q;
    ld_ready   = 1'b0;
    im_we      = 1'b0;
    sel_load   = 1'b0;
    pc_reset   = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_reset = 1'b1;
        if (bus.start) begin
          state_d = LOAD;
          addr_d  = '0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        sel_load = 1'b1;
        im_we    = bus.ld_valid;
        if (bus.ld_valid) begin
          // Saturate at the top address; a non-last word there ends the image as an error.
          if (addr_q != '1) addr_d = addr_q + 1'b1;
          if (bus.ld_last) begin
            state_d = CLEAR;
          end else if (addr_q == '1) begin
            state_d = CLEAR;
            err_d   = 1'b1;
          end
        end
      end
      CLEAR: begin
        pc_reset   = 1'b1;
        ifid_flush = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        if (bus.halt_instr) begin
          state_d = HALT;
        end else if (bus.branch_taken) begin
          state_d = FLUSH;
          fcnt_d  = 3'(FLUSH_CYCLES - 1);
        end else if (bus.hazard) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (!bus.hazard) state_d = RUN;
      end
      FLUSH: begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        if (fcnt_q == '0) state_d = RUN;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      HALT: begin
        if (bus.start) begin
          state_d = LOAD;
          addr_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ld_ready    = ld_ready;
  assign bus.im_WE       = im_we;
  assign bus.im_sel_load = sel_load;
  assign bus.pc_RESET    = pc_reset;
  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.im_ADDRESS  = addr_q;
  assign bus.im_DATA     = (state_q == LOAD) ? bus.ld_data : '0;
  assign bus.load_err    = err_q;
  assign bus.state_o     = state_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d, stall_q, stall_d;

  always_comb begin
    cyc_d   = cyc_q;
    stall_d = stall_q;
    if (start_ok) begin
      cyc_d   = '0;
      stall_d = '0;
    end else begin
      if (state_q == RUN || state_q == STALL || state_q == FLUSH) cyc_d   = cyc_q + 1'b1;
      if (state_q == STALL || state_q == FLUSH)                   stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
    end
  end

  assign bus.cyc_cnt   = cyc_q;
  assign bus.stall_cnt = stall_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif
endmodule
